// File: rtl/coeff_seq_pkg.sv
// Shared definitions for the coefficient load sequencer: datapath opcodes,
// register-file addresses and the sequencer state encoding.
package coeff_seq_pkg;

  // Datapath opcodes
  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpCopy  = 3'b001;
  localparam logic [2:0] OpLoad1 = 3'b010;
  localparam logic [2:0] OpLoad2 = 3'b011;
  localparam logic [2:0] OpAdd   = 3'b100;
  localparam logic [2:0] OpSub   = 3'b101;
  localparam logic [2:0] OpMul   = 3'b110;

  // Datapath register file addresses
  localparam logic [3:0] R00 = 4'd0;
  localparam logic [3:0] R01 = 4'd1;
  localparam logic [3:0] R02 = 4'd2;
  localparam logic [3:0] R03 = 4'd3;
  localparam logic [3:0] R04 = 4'd4;
  localparam logic [3:0] R05 = 4'd5;
  localparam logic [3:0] R06 = 4'd6;
  localparam logic [3:0] R07 = 4'd7;
  localparam logic [3:0] R08 = 4'd8;
  localparam logic [3:0] R09 = 4'd9;
  localparam logic [3:0] R10 = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StAcquire,
    StWaitData,
    StIssue,
    StDone
  } seq_state_e;

endpackage

// File: rtl/flex_counter.sv
// Parameterised rollover counter.
// Counts 0..rollover_val_i, wrapping to 0 when enabled at the rollover value.
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   clear_i         synchronous clear (wins over count_enable_i)
//   count_enable_i  advance the count this cycle
//   rollover_val_i  terminal count
//   count_o         current count
//   rollover_o      count_o equals rollover_val_i
module flex_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear_i,
  input  logic            count_enable_i,
  input  logic [CntW-1:0] rollover_val_i,
  output logic [CntW-1:0] count_o,
  output logic            rollover_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_enable_i) begin
      if (cnt_q == rollover_val_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign rollover_o = (cnt_q == rollover_val_i);

endmodule

// File: rtl/coeff_load_sequencer.sv
// Coefficient load sequencer.
// Waits for the FIR sample controller to go idle, takes ownership of the shared
// datapath and writes NUM_COEFF streamed coefficients into registers
// BASE_REG..BASE_REG+NUM_COEFF-1 with LOAD2 operations, then releases it.
// Optional build macro COEFF_TIMEOUT_EN: abandon the sequence after TIMEOUT_CYC
// consecutive WAIT_DATA cycles without a coefficient handshake.
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   load_start_i   one-cycle request to start a load sequence
//   fir_busy_i     sample controller currently owns the datapath
//   coeff_valid_i  coeff_data_i valid
//   coeff_data_i   coefficient value
//   coeff_ready_o  coefficient accepted this cycle (when valid)
//   dp_grant_o     sequencer owns the datapath
//   op_o, dest_o   datapath opcode / destination register
//   ext_data2_o    registered coefficient for LOAD2
//   coeff_idx_o    index of the next coefficient
//   coeff_done_o   one-cycle pulse at sequence completion
//   err_o          sticky protocol error
module coeff_load_sequencer
  import coeff_seq_pkg::*;
#(
  parameter int unsigned NUM_COEFF   = 4,
  parameter logic [3:0]  BASE_REG    = 4'd6,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned IdxW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_start_i,
  input  logic              fir_busy_i,
  input  logic              coeff_valid_i,
  input  logic [DATA_W-1:0] coeff_data_i,
  output logic              coeff_ready_o,
  output logic              dp_grant_o,
  output logic [2:0]        op_o,
  output logic [3:0]        dest_o,
  output logic [DATA_W-1:0] ext_data2_o,
  output logic [IdxW-1:0]   coeff_idx_o,
  output logic              coeff_done_o,
  output logic              err_o
);

  seq_state_e        state_q, state_d;
  logic              dp_grant_q, dp_grant_d;
  logic              coeff_done_q, coeff_done_d;
  logic              err_q, err_d;
  logic              fir_busy_q;
  logic [DATA_W-1:0] ext_data2_q, ext_data2_d;

  logic              idx_en, idx_clr, idx_last;
  logic [IdxW-1:0]   idx_q;
  logic              timeout;

  flex_counter #(
    .CntW (IdxW)
  ) u_idx_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (idx_clr),
    .count_enable_i (idx_en),
    .rollover_val_i (IdxW'(NUM_COEFF - 1)),
    .count_o        (idx_q),
    .rollover_o     (idx_last)
  );

`ifdef COEFF_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC) + 1;

  logic           to_en, to_hit;
  logic [ToW-1:0] to_cnt;

  // Counts idle WAIT_DATA cycles; any handshake or leaving WAIT_DATA clears it.
  assign to_en = (state_q == StWaitData) && !coeff_valid_i;

  flex_counter #(
    .CntW (ToW)
  ) u_timeout_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (!to_en),
    .count_enable_i (to_en),
    .rollover_val_i (ToW'(TIMEOUT_CYC - 1)),
    .count_o        (to_cnt),
    .rollover_o     (to_hit)
  );

  // The TIMEOUT_CYC-th consecutive idle cycle ends the sequence.
  assign timeout = to_en && to_hit;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    dp_grant_d    = dp_grant_q;
    coeff_done_d  = 1'b0;
    err_d         = err_q;
    ext_data2_d   = ext_data2_q;
    idx_en        = 1'b0;
    idx_clr       = 1'b0;
    coeff_ready_o = 1'b0;
    op_o          = OpNop;
    dest_o        = R00;

    // Requests while busy are flagged and dropped, never queued.
    if (state_q != StIdle && load_start_i) begin
      err_d = 1'b1;
    end
    // Sample controller grabbing the datapath while we own it.
    if (dp_grant_q && fir_busy_i && !fir_busy_q) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          err_d   = 1'b0;
          state_d = StAcquire;
        end
      end
      StAcquire: begin
        if (!fir_busy_i) begin
          dp_grant_d = 1'b1;
          state_d    = StWaitData;
        end
      end
      StWaitData: begin
        coeff_ready_o = 1'b1;
        if (coeff_valid_i) begin
          ext_data2_d = coeff_data_i;
          state_d     = StIssue;
        end else if (timeout) begin
          err_d      = 1'b1;
          dp_grant_d = 1'b0;
          idx_clr    = 1'b1;
          state_d    = StIdle;
        end
      end
      StIssue: begin
        op_o   = OpLoad2;
        dest_o = BASE_REG + 4'(idx_q);
        if (idx_last) begin
          coeff_done_d = 1'b1;
          state_d      = StDone;
        end else begin
          idx_en  = 1'b1;
          state_d = StWaitData;
        end
      end
      StDone: begin
        dp_grant_d = 1'b0;
        idx_clr    = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      dp_grant_q   <= 1'b0;
      coeff_done_q <= 1'b0;
      err_q        <= 1'b0;
      fir_busy_q   <= 1'b0;
      ext_data2_q  <= '0;
    end else begin
      state_q      <= state_d;
      dp_grant_q   <= dp_grant_d;
      coeff_done_q <= coeff_done_d;
      err_q        <= err_d;
      fir_busy_q   <= fir_busy_i;
      ext_data2_q  <= ext_data2_d;
    end
  end

  assign dp_grant_o   = dp_grant_q;
  assign coeff_done_o = coeff_done_q;
  assign err_o        = err_q;
  assign ext_data2_o  = ext_data2_q;
  assign coeff_idx_o  = idx_q;

endmodule
